// File: rtl/io_load_pkg.sv
// Shared types and constants for the RLE load controller: FSM states,
// compressed-word field positions and the default memory map.
package io_load_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_CAPT  = 3'd2,
        S_WRITE = 3'd3,
        S_END   = 3'd4
    } state_e;

    // Compressed host word layout: {count[15:8], value[7:0]}
    localparam int COUNT_MSB = 15;
    localparam int COUNT_LSB = 8;
    localparam int VALUE_MSB = 7;
    localparam int VALUE_LSB = 0;

    // A count of zero terminates the stream
    localparam logic [7:0] END_MARKER = 8'd0;

    // Default memory map (byte addresses)
    localparam logic [15:0] DEF_CNN_BASE = 16'h0000;
    localparam logic [15:0] DEF_CNN_SIZE = 16'h4000;
    localparam logic [15:0] DEF_IMG_BASE = 16'h4000;
    localparam logic [15:0] DEF_IMG_SIZE = 16'hC000;

    function automatic logic [7:0] word_count(input logic [15:0] w);
        return w[COUNT_MSB:COUNT_LSB];
    endfunction

    function automatic logic [7:0] word_value(input logic [15:0] w);
        return w[VALUE_MSB:VALUE_LSB];
    endfunction

endpackage

// File: rtl/io_rle_load_ctrl_decoder.sv
// Run-length word decoder: holds the remaining run length and the byte
// value of the word being expanded.
module rle_word_decoder
    import io_load_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,      // capture a new compressed word
    input  logic [15:0] word_i,
    input  logic        dec_i,       // one byte of the run consumed
    output logic        is_end_o,    // word_i carries the end marker
    output logic        run_zero_o,  // this decrement empties the run
    output logic [7:0]  byte_o
);

    logic [7:0] run_q, run_d;
    logic [7:0] byte_q, byte_d;

    // Run/byte registers
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            run_q  <= '0;
            byte_q <= '0;
        end else begin
            run_q  <= run_d;
            byte_q <= byte_d;
        end
    end

    // Load a fresh word or count the run down
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
        run_d  = run_q;
        byte_d = byte_q;
        if (load_i) begin
            run_d  = word_count(word_i);
            byte_d = word_value(word_i);
        end else if (dec_i && (run_q != 8'd0)) begin
            run_d = run_q - 8'd1;
        end
    end

    assign is_end_o   = (word_count(word_i) == END_MARKER);
    assign run_zero_o = dec_i && (run_q == 8'd1);
    assign byte_o     = byte_q;

endmodule

// File: rtl/io_rle_load_ctrl.sv
// Host load sequencer: decodes host commands, paces the host one word at
// a time and expands run-length words into byte writes to the CNN or
// image region, with overflow protection and abort-by-new-load.
module io_rle_load_ctrl
    import io_load_pkg::*;
#(
    parameter int unsigned         ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]   CNN_BASE = ADDR_W'(DEF_CNN_BASE),
    parameter logic [ADDR_W-1:0]   CNN_SIZE = ADDR_W'(DEF_CNN_SIZE),
    parameter logic [ADDR_W-1:0]   IMG_BASE = ADDR_W'(DEF_IMG_BASE),
    parameter logic [ADDR_W-1:0]   IMG_SIZE = ADDR_W'(DEF_IMG_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              interrupt,
    input  logic              load,
    input  logic              cnn,
    input  logic [15:0]       data,
    output logic              done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    output logic              start_proc,
    output logic              busy,
    output logic              cnn_loaded,
    output logic              img_loaded,
    output logic              overflow
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] remain_q, remain_d;
    logic              region_cnn_q, region_cnn_d;
    logic              start_q, start_d;
    logic              cnn_loaded_q, cnn_loaded_d;
    logic              img_loaded_q, img_loaded_d;
    logic              overflow_q, overflow_d;

    logic              cmd_load;
    logic              room;
    logic              in_write;
    logic              accept;
    logic              drop;
    logic              step;
    logic              word_load;
    logic              is_end;
    logic              run_zero;
    logic [7:0]        run_byte;

    // A load command is honoured in every state; it restarts the sequencer
    assign cmd_load  = interrupt && load;
    assign room      = (remain_q != '0);
    assign in_write  = (state_q == S_WRITE);
    assign accept    = in_write && room && mem_ready;
    // Region exhausted: bytes are discarded at one per cycle without a handshake
    assign drop      = in_write && !room;
    assign step      = accept || drop;
    assign word_load = (state_q == S_CAPT) && !is_end && !cmd_load;

    rle_word_decoder u_dec (
        .clk        (clk),
        .rst        (rst),
        .load_i     (word_load),
        .word_i     (data),
        .dec_i      (step),
        .is_end_o   (is_end),
        .run_zero_o (run_zero),
        .byte_o     (run_byte)
    );

    // State, pointer and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            remain_q     <= '0;
            region_cnn_q <= 1'b0;
            start_q      <= 1'b0;
            cnn_loaded_q <= 1'b0;
            img_loaded_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            remain_q     <= remain_d;
            region_cnn_q <= region_cnn_d;
            start_q      <= start_d;
            cnn_loaded_q <= cnn_loaded_d;
            img_loaded_q <= img_loaded_d;
            overflow_q   <= overflow_d;
        end
    end

    // Next-state logic: word pacing, run expansion and command handling
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        remain_d     = remain_q;
        region_cnn_d = region_cnn_q;
        start_d      = 1'b0;
        cnn_loaded_d = cnn_loaded_q;
        img_loaded_d = img_loaded_q;
        overflow_d   = overflow_q;

        unique case (state_q)
            S_IDLE: begin
                // Process command only when idle; a pulse follows next cycle
                if (interrupt && !load) begin
                    start_d = 1'b1;
                end
            end
            S_REQ: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                state_d = is_end ? S_END : S_WRITE;
            end
            S_WRITE: begin
                if (accept) begin
                    ptr_d    = ptr_q + ADDR_W'(1);
                    remain_d = remain_q - ADDR_W'(1);
                end
                if (drop) begin
                    overflow_d = 1'b1;
                end
                if (run_zero) begin
                    state_d = S_REQ;
                end
            end
            S_END: begin
                state_d = S_IDLE;
                if (!overflow_q) begin
                    if (region_cnn_q) begin
                        cnn_loaded_d = 1'b1;
                    end else begin
                        img_loaded_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A load command (from idle, or aborting a stream) overrides the
        // above: no loaded flag is granted to the stream it replaces.
        if (cmd_load) begin
            state_d      = S_REQ;
            region_cnn_d = cnn;
            ptr_d        = cnn ? CNN_BASE : IMG_BASE;
            remain_d     = cnn ? CNN_SIZE : IMG_SIZE;
            overflow_d   = 1'b0;
            cnn_loaded_d = cnn ? 1'b0 : cnn_loaded_q;
            img_loaded_d = cnn ? img_loaded_q : 1'b0;
        end
    end

    assign done       = (state_q == S_REQ);
    assign mem_we     = in_write && room;
    assign mem_addr   = ptr_q;
    assign mem_wdata  = run_byte;
    assign start_proc = start_q;
    assign busy       = (state_q != S_IDLE);
    assign cnn_loaded = cnn_loaded_q;
    assign img_loaded = img_loaded_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/io_rle_load_ctrl.md
Name: io_rle_load_ctrl

Overview:
- Sequences loading of compressed CNN weights and images from the host bus into accelerator memory.
- Decodes each host command (interrupt + load/cnn) and paces the host word by word with a done request pulse.
- Run-length decodes each 16-bit word into byte writes to the CNN or image region.
- Issues a one-cycle start_proc pulse on the process command.

Parameters:
ADDR_W, 16, memory byte-address width
CNN_BASE, 16'h0000, first byte address of CNN region
CNN_SIZE, 16'h4000, CNN region size in bytes
IMG_BASE, 16'h4000, first byte address of image region
IMG_SIZE, 16'hC000, image region size in bytes

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
interrupt  in  1  host command strobe, sampled on rising edge
load  in  1  1 = load command, 0 = process command (valid with interrupt)
cnn  in  1  1 = CNN stream, 0 = image stream (valid with interrupt and load=1)
data  in  16  compressed word {count[15:8], value[7:0]}
done  out  1  one-cycle request for next host word
mem_we  out  1  byte write strobe
mem_addr  out  ADDR_W  byte write address
mem_wdata  out  8  byte write data
mem_ready  in  1  memory accepts write this cycle when high
start_proc  out  1  one-cycle process-start pulse
busy  out  1  high in any state other than IDLE
cnn_loaded  out  1  sticky, set on clean CNN stream end
img_loaded  out  1  sticky, set on clean image stream end
overflow  out  1  sticky, a write beyond its region was dropped

Behaviour:
- Reset (async, any state):
  - State = IDLE.
  - done, mem_we, start_proc, busy, cnn_loaded, img_loaded, overflow = 0.
  - mem_addr = 0, mem_wdata = 0, internal counters = 0.
- States: IDLE, REQ, CAPT, WRITE, END.
- IDLE, interrupt=1:
  - load=1: latch region (cnn), ptr = region base, remain = region size, go to REQ.
  - load=0: start_proc=1 for exactly the next cycle; stay in IDLE.
- REQ: done=1 for exactly one cycle, then go to CAPT.
- CAPT: the host updates data on the falling edge inside the done cycle. data is captured on the rising edge that ends the CAPT cycle.
  - count=0: end-of-stream; go to END.
  - Else: run = count (1..255), byte = value; go to WRITE.
- WRITE:
  - mem_we=1, mem_addr=ptr, mem_wdata=byte; held stable while mem_ready=0.
  - Each cycle with mem_we=1 and mem_ready=1: ptr+1, remain-1, run-1.
  - When run reaches 0, go to REQ. Throughput is 1 byte/cycle with mem_ready stuck high.
  - Word-to-word gap is 2 cycles (REQ + CAPT).
- Region full (remain=0) while run>0:
  - mem_we forced 0, overflow set, run still decremented 1/cycle without waiting for mem_ready.
  - The stream is drained until its end marker.
- END:
  - One cycle; sets cnn_loaded or img_loaded only if no overflow occurred during this stream; then IDLE.
  - Loaded flags clear only on reset, or when a new load for the same region starts.
- ptr arithmetic: ADDR_W-bit, no wrap; overflow detection is by remain.
- interrupt while busy, load=1: abort the current stream. No further writes for it, and no loaded flag.
  - Restart as a new IDLE load command on the next cycle, with the newly sampled cnn.
- interrupt while busy, load=0: ignored; start_proc is never issued while busy.
- interrupt coinciding with a WRITE handshake: that write completes (it is already accepted), then the abort applies.
- The overflow flag is per-controller sticky. It is cleared only by reset or a new load command.

Decomposition:
- Package io_load_pkg:
  - State enum.
  - Field constants: COUNT_MSB=15, COUNT_LSB=8, VALUE_MSB=7, VALUE_LSB=0, END_MARKER=8'd0.
  - Default region base/size constants.
- One sub-module: rle_word_decoder. Holds run/byte registers; load from a word, decrement on accept, run_zero flag.
- Top holds the FSM, region pointers and flags.

Test Plan:
- CNN load, words 16'h03AA, 16'h0155, 16'h0000, mem_ready=1 -> writes AA@0,1,2 and 55@3. done pulses 3 times, cnn_loaded=1, 11 cycles interrupt-to-IDLE.
- Image load, word 16'h0207, mem_ready low 2 cycles on first byte -> 07@4000 held 3 cycles, then 07@4001. No duplicate or lost byte; img_loaded=1 after 16'h0000.
- Process command (interrupt=1, load=0) in IDLE -> start_proc high exactly 1 cycle; busy stays 0. Repeated while busy -> no pulse.
- CNN_SIZE=4, words 16'h06FF, 16'h0000 -> 4 writes at 0..3, 2 dropped. overflow=1, cnn_loaded=0, FSM returns to IDLE.
- Mid-stream interrupt, load=1, cnn=0 during WRITE of 16'h0511 -> at most the in-flight write completes. Next write goes to IMG_BASE; cnn_loaded stays 0.
- rst asserted asynchronously mid-WRITE (between edges) -> all outputs 0 immediately, state IDLE. A new load after release proceeds normally.
